// File: rtl/alu_cmd_issue.sv
// Command queue and issue sequencer for an external combinational ALU.
// Commands are buffered in a small FIFO, issued one at a time, and each result is held until it is accepted.
module alu_cmd_issue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [4:0]       cmd_shamt,

    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shiftValue,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_sign,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero,
    output logic             res_sign,
    output logic             res_illegal,

    output logic             busy,
    output logic [15:0]      issued_cnt
);

    // state   | meaning
    // IDLE    | waiting for a queued command
    // ISSUE   | operands driven to the ALU, settling
    // CAPTURE | ALU outputs sampled into the result register
    // HOLD    | result presented, waiting for res_ready
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_HOLD
    } state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [4:0]       sh;
    } cmd_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ready_en;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    state_t        state;
    state_t        state_nxt;
    logic          load_res;
    logic          clr_valid;

    logic [WIDTH-1:0] add_sum;
    logic             carry_calc;
    logic             illegal_calc;
    logic             handshake;
    logic [15:0]      issued_q;
    logic [15:0]      issued_nxt;

    assign fifo_full  = (count == CW'(DEPTH));
    assign fifo_empty = (count == '0);
    assign cmd_ready  = ready_en && !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign head       = mem[rd_ptr];

    // Keeps cmd_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: cmd_opcode, a: cmd_a, b: cmd_b, sh: cmd_shamt};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_res  = 1'b0;
        clr_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                load_res  = 1'b1;
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    clr_valid = 1'b1;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = S_ISSUE;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode     <= '0;
            alu_input1     <= '0;
            alu_input2     <= '0;
            alu_shiftValue <= '0;
        end else if (pop) begin
            alu_opcode     <= head.op;
            alu_input1     <= head.a;
            alu_input2     <= head.b;
            alu_shiftValue <= head.sh;
        end
    end

    // Unsigned add overflows exactly when the wrapped sum is below an operand.
    assign add_sum      = alu_input1 + alu_input2;
    assign illegal_calc = (alu_opcode > 4'd4);

    always_comb begin
        carry_calc = 1'b0;
        case (alu_opcode)
            4'd0:    carry_calc = (add_sum < alu_input1);
            4'd1:    carry_calc = (alu_input1 < alu_input2);
            default: carry_calc = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_carry   <= 1'b0;
            res_zero    <= 1'b0;
            res_sign    <= 1'b0;
            res_illegal <= 1'b0;
        end else if (load_res) begin
            res_valid   <= 1'b1;
            res_data    <= alu_result;
            res_carry   <= carry_calc;
            res_zero    <= alu_zero;
            res_sign    <= alu_sign;
            res_illegal <= illegal_calc;
        end else if (clr_valid) begin
            res_valid   <= 1'b0;
        end
    end

    assign handshake  = res_valid && res_ready;
    assign issued_nxt = issued_q + {15'd0, handshake};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= '0;
        end else begin
            issued_q <= issued_nxt;
        end
    end

    assign issued_cnt = issued_q;
    assign busy       = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue: behavioural ALU stub, scoreboard queue of expected results.
module tb_alu_cmd_issue;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_opcode = '0;
    logic [W-1:0]  cmd_a = '0;
    logic [W-1:0]  cmd_b = '0;
    logic [4:0]    cmd_shamt = '0;
    logic [3:0]    alu_opcode;
    logic [W-1:0]  alu_input1;
    logic [W-1:0]  alu_input2;
    logic [4:0]    alu_shiftValue;
    logic [W-1:0]  alu_result;
    logic          alu_zero;
    logic          alu_sign;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_data;
    logic          res_carry;
    logic          res_zero;
    logic          res_sign;
    logic          res_illegal;
    logic          busy;
    logic [15:0]   issued_cnt;

    typedef struct packed {
        logic [W-1:0] data;
        logic         carry;
        logic         zero;
        logic         sign;
        logic         illegal;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_cnt = '0;

    alu_cmd_issue #(.WIDTH(W), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shiftValue(alu_shiftValue),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero),
        .res_sign(res_sign), .res_illegal(res_illegal),
        .busy(busy), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    // Downstream ALU: 0 add, 1 sub, 2 sll, 3 and, 4 or, anything else yields 0.
    always_comb begin
        case (alu_opcode)
            4'd0:    alu_result = alu_input1 + alu_input2;
            4'd1:    alu_result = alu_input1 - alu_input2;
            4'd2:    alu_result = alu_input1 << alu_shiftValue;
            4'd3:    alu_result = alu_input1 & alu_input2;
            4'd4:    alu_result = alu_input1 | alu_input2;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
        alu_sign = alu_result[W-1];
    end

    function automatic exp_t exp_fn(input logic [3:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [4:0] sh);
        exp_t       e;
        logic [W:0] s;
        e = '0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                e.data  = s[W-1:0];
                e.carry = s[W];
            end
            4'd1: begin
                e.data  = a - b;
                e.carry = (a < b);
            end
            4'd2:    e.data = a << sh;
            4'd3:    e.data = a & b;
            4'd4:    e.data = a | b;
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.data == '0);
        e.sign = e.data[W-1];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge; records the expectation once the DUT takes the command.
    task automatic push(input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] sh);
        int n;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_shamt  = sh;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", cmd_ready, 1);
        if (cmd_ready) begin
            @(posedge clk);
            sb.push_back(exp_fn(op, a, b, sh));
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input int n, input int budget);
        int   got;
        int   cyc;
        exp_t e;
        got = 0;
        cyc = 0;
        while (got < n && cyc < budget) begin
            if (res_valid && res_ready) begin
                check("sb_nonempty", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("res_data",    res_data,    e.data);
                    check("res_carry",   res_carry,   e.carry);
                    check("res_zero",    res_zero,    e.zero);
                    check("res_sign",    res_sign,    e.sign);
                    check("res_illegal", res_illegal, e.illegal);
                end
                got++;
                exp_cnt = exp_cnt + 16'd1;
            end
            @(negedge clk);
            cyc++;
        end
        check("collect_count", got, n);
        check("issued_cnt", issued_cnt, exp_cnt);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!res_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", res_valid, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_res_valid", res_valid, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_issued", issued_cnt, 0);
        check("rst_alu_op", {alu_opcode, alu_input1, alu_input2[11:0]}, 0);
        check("rst_res_data", res_data, 0);
        rst_n = 1'b1;
        #1 check("rel_cmd_ready_low", cmd_ready, 0);
        @(negedge clk);
        check("rel_cmd_ready_high", cmd_ready, 1);

        // ADD with carry and the three-cycle latency after the push edge
        res_ready = 1'b1;
        push(4'd0, 16'hFFFF, 16'h0001, 5'd0);
        check("lat_n0", res_valid, 0);
        check("busy_after_push", busy, 1);
        @(negedge clk); check("lat_n1", res_valid, 0);
        @(negedge clk); check("lat_n2", res_valid, 0);
        @(negedge clk); check("lat_n3", res_valid, 1);
        collect(1, 10);

        // SUB with borrow, then SLL into the sign bit
        push(4'd1, 16'h0003, 16'h0005, 5'd0);
        collect(1, 10);
        push(4'd2, 16'h0001, 16'h0000, 5'd15);
        collect(1, 10);

        // Illegal opcode
        push(4'hA, 16'h1234, 16'h5678, 5'd3);
        collect(1, 10);
        check("idle_busy", busy, 0);

        // Random batch queued behind a stalled result
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 5'($urandom_range(0, 31)));
        end
        res_ready = 1'b1;
        collect(5, 40);

        // Five back-to-back with res_ready low: 4 queued plus 1 in flight fills the path
        res_ready = 1'b0;
        push(4'd0, 16'h0010, 16'h0020, 5'd0);
        push(4'd1, 16'h0100, 16'h0001, 5'd0);
        push(4'd2, 16'h00F0, 16'h0000, 5'd4);
        push(4'd3, 16'hF0F0, 16'h3C3C, 5'd0);
        push(4'd4, 16'hA000, 16'h0005, 5'd0);
        check("full_cmd_ready", cmd_ready, 0);
        check("full_busy", busy, 1);
        wait_valid(10);
        for (int i = 0; i < 4; i++) begin
            check("hold_data", res_data, sb[0].data);
            check("hold_valid", res_valid, 1);
            check("hold_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        collect(5, 40);

        // Reset while holding a result with three commands still queued
        res_ready = 1'b0;
        push(4'd0, 16'h0001, 16'h0001, 5'd0);
        push(4'd0, 16'h0002, 16'h0002, 5'd0);
        push(4'd0, 16'h0003, 16'h0003, 5'd0);
        push(4'd0, 16'h0004, 16'h0004, 5'd0);
        wait_valid(10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        check("mid_rst_issued", issued_cnt, 0);
        sb.delete();
        exp_cnt = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_no_result", res_valid, 0);
            check("post_rst_busy", busy, 0);
        end
        check("post_rst_issued", issued_cnt, 0);

        // Counter wrap: preload the next-value net for a single edge, then one transfer
        force dut.issued_nxt = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.issued_nxt;
        #1 check("preload_issued", issued_cnt, 16'hFFFF);
        exp_cnt = 16'hFFFF;
        push(4'd0, 16'h0001, 16'h0001, 5'd0);
        collect(1, 10);
        check("wrap_issued", issued_cnt, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
